// File: rtl/adder_arbiter.sv
// Round-robin arbitrated shared adder: N requesters share one registered W-bit adder
// whose results queue in a 2-entry response FIFO, with credit-based issue throttling.
module adder_arbiter #(
  parameter  int N  = 4,
  parameter  int W  = 32,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req_valid,
  output logic [N-1:0]          req_ready,
  input  logic [N-1:0][W-1:0]   req_a,
  input  logic [N-1:0][W-1:0]   req_b,
  input  logic [N-1:0]          req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IW-1:0]         rsp_id,
  output logic [W-1:0]          rsp_y,
  output logic                  rsp_cout
);

  typedef struct packed {
    logic [IW-1:0] id;
    logic          cout;
    logic [W-1:0]  y;
  } rsp_t;

  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt_idx;
  logic          found;
  logic          issue;
  logic          pop;
  logic          credit_ok;
  logic [1:0]    count;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [W:0]    sum;
  rsp_t          mem [2];

  // Round-robin search starting at ptr, wrapping from N-1 back to 0.
  // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    int idx;
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end

  // The adder result lands in the FIFO at the issue edge, so nothing is ever
  // in flight outside the FIFO; a same-cycle pop frees a slot for the issue.
  assign pop       = rsp_valid & rsp_ready;
  assign credit_ok = (count != 2'd2) | pop;
  assign issue     = rst_n & found & credit_ok;
  assign req_ready = issue ? (N'(1) << gnt_idx) : '0;

  assign sum = {1'b0, req_a[gnt_idx]} + {1'b0, req_b[gnt_idx]} + {{W{1'b0}}, req_cin[gnt_idx]};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      // NOTE: the two storage entries are reset too, so the head reads zero after reset.
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (issue) begin
        mem[wr_ptr] <= '{id: gnt_idx, cout: sum[W], y: sum[W-1:0]};
        wr_ptr      <= ~wr_ptr;
        ptr         <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({issue, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rsp_valid = rst_n & (count != 2'd0);
  assign rsp_id    = mem[rd_ptr].id;
  assign rsp_y     = mem[rd_ptr].y;
  assign rsp_cout  = mem[rd_ptr].cout;

endmodule
